// File: rtl/rr_arb_n.sv
// rr_arb_n: parametrised round-robin arbiter with burst credit and packet lock.
//
// Ports:
//   clks        clock, all logic on rising edge
//   reset       asynchronous active-high reset
//   req         per-channel request (level)
//   weight      per-channel burst credit, channel i at [i*WT_W +: WT_W]; 0 acts as 1
//   lock_en     packet mode: grant held until a transfer with eop=1
//   eop         end-of-packet qualifier, sampled only on a transfer
//   gnt_rdy     downstream accepts the current transfer
//   gnt_vld     registered grant valid
//   gnt_num     registered granted channel index
//   gnt_onehot  one-hot of gnt_num, all zero when gnt_vld=0
module rr_arb_n #(
    parameter int unsigned REQ_NUM   = 8,
    parameter int unsigned REQ_NUM_W = 3,
    parameter int unsigned WT_W      = 4
) (
    input  logic                    clks,
    input  logic                    reset,
    input  logic [REQ_NUM-1:0]      req,
    input  logic [REQ_NUM*WT_W-1:0] weight,
    input  logic                    lock_en,
    input  logic                    eop,
    input  logic                    gnt_rdy,
    output logic                    gnt_vld,
    output logic [REQ_NUM_W-1:0]    gnt_num,
    output logic [REQ_NUM-1:0]      gnt_onehot
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t               state_q, state_d;
    logic [REQ_NUM_W-1:0] ptr_q, ptr_d;
    logic [REQ_NUM_W-1:0] gnt_num_q, gnt_num_d;
    logic                 gnt_vld_q, gnt_vld_d;
    logic [WT_W-1:0]      credit_q, credit_d;

    logic [REQ_NUM_W-1:0] base;
    logic [REQ_NUM_W-1:0] win;
    logic                 any_req;
    logic [WT_W-1:0]      win_credit;
    logic [WT_W-1:0]      credit_dec;
    logic                 xfer;
    logic                 unit_done;
    logic                 stay;
    int unsigned          idx;
    logic [REQ_NUM_W-1:0] idx_w;

    // A release re-arbitrates against the channel being released, which is
    // the value ptr takes on that same edge; in IDLE the stored ptr is used.
    assign base = (state_q == HOLD) ? gnt_num_q : ptr_q;

    // First requester strictly after base, wrapping modulo REQ_NUM; base
    // itself is examined last so it has lowest priority.
    always_comb begin
        win     = '0;
        any_req = 1'b0;
        idx     = 0;
        idx_w   = '0;
        for (int unsigned i = 1; i <= REQ_NUM; i++) begin
            idx = int'(base) + i;
            if (idx >= REQ_NUM) begin
                idx = idx - REQ_NUM;
            end
            idx_w = REQ_NUM_W'(idx);
            if (!any_req && req[idx_w]) begin
                win     = idx_w;
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        win_credit = '0;
        for (int unsigned j = 0; j < REQ_NUM; j++) begin
            if (REQ_NUM_W'(j) == win) begin
                win_credit = weight[j*WT_W +: WT_W];
            end
        end
        if (win_credit == '0) begin
            win_credit = WT_W'(1);
        end
    end

    assign xfer       = gnt_vld_q & gnt_rdy;
    assign unit_done  = xfer & (~lock_en | eop);
    assign credit_dec = credit_q - WT_W'(1);
    assign stay       = (credit_dec != '0) & req[gnt_num_q] & ~lock_en;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_num_d = gnt_num_q;
        gnt_vld_d = gnt_vld_q;
        credit_d  = credit_q;
        case (state_q)
            IDLE: begin
                gnt_vld_d = 1'b0;
                if (any_req) begin
                    gnt_num_d = win;
                    gnt_vld_d = 1'b1;
                    credit_d  = win_credit;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                if (unit_done) begin
                    credit_d = credit_dec;
                    if (!stay) begin
                        ptr_d = gnt_num_q;
                        if (any_req) begin
                            gnt_num_d = win;
                            gnt_vld_d = 1'b1;
                            credit_d  = win_credit;
                        end else begin
                            gnt_vld_d = 1'b0;
                            state_d   = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                gnt_vld_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clks or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= REQ_NUM_W'(REQ_NUM - 1);
            gnt_num_q <= '0;
            gnt_vld_q <= 1'b0;
            credit_q  <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_num_q <= gnt_num_d;
            gnt_vld_q <= gnt_vld_d;
            credit_q  <= credit_d;
        end
    end

    always_comb begin
        gnt_onehot = '0;
        if (gnt_vld_q) begin
            gnt_onehot[gnt_num_q] = 1'b1;
        end
    end

    assign gnt_vld = gnt_vld_q;
    assign gnt_num = gnt_num_q;

endmodule

// File: tb/tb_rr_arb_n.sv
// tb_rr_arb_n: scoreboard bench for rr_arb_n (REQ_NUM=8, WT_W=4).
// Expected grant indices are queued as each scenario is set up and popped
// whenever a transfer (gnt_vld & gnt_rdy) is seen on the falling edge.
module tb_rr_arb_n;

    localparam int unsigned N  = 8;
    localparam int unsigned NW = 3;
    localparam int unsigned WW = 4;

    logic          clks    = 1'b0;
    logic          reset   = 1'b1;
    logic [N-1:0]  req     = '0;
    logic [N*WW-1:0] weight = '0;
    logic          lock_en = 1'b0;
    logic          eop     = 1'b0;
    logic          gnt_rdy = 1'b0;
    logic          gnt_vld;
    logic [NW-1:0] gnt_num;
    logic [N-1:0]  gnt_onehot;

    int checks = 0;
    int errors = 0;
    logic [NW-1:0] exp_q[$];

    rr_arb_n #(.REQ_NUM(N), .REQ_NUM_W(NW), .WT_W(WW)) dut (
        .clks       (clks),
        .reset      (reset),
        .req        (req),
        .weight     (weight),
        .lock_en    (lock_en),
        .eop        (eop),
        .gnt_rdy    (gnt_rdy),
        .gnt_vld    (gnt_vld),
        .gnt_num    (gnt_num),
        .gnt_onehot (gnt_onehot)
    );

    always #5 clks = ~clks;

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset();
        reset   = 1'b1;
        req     = '0;
        gnt_rdy = 1'b0;
        lock_en = 1'b0;
        eop     = 1'b0;
        for (int i = 0; i < N; i++) weight[i*WW +: WW] = WW'(1);
        exp_q.delete();
        @(negedge clks);
        @(negedge clks);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = '1;
        repeat (2) @(negedge clks);
        checks++;
        if (gnt_vld !== 1'b0 || gnt_num !== '0 || gnt_onehot !== '0) begin
            errors++;
            $display("FAIL reset_outputs got vld=%b num=%0d oh=%b want 0 0 0", gnt_vld, gnt_num, gnt_onehot);
        end
        req   = '0;
        reset = 1'b0;
        @(negedge clks);
        checks++;
        if (gnt_vld !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req got vld=%b want 0", gnt_vld);
        end
    endtask

    // Shared body for the free-running scenarios: pops one expected grant per
    // transfer and, once granting has started, requires gnt_vld to stay high.
    task automatic run_stream(input string name, input bit need_cont);
        logic [N-1:0]  oh;
        logic [NW-1:0] e;
        bit started;
        started = 1'b0;
        for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
            @(negedge clks);
            if (need_cont && started) begin
                checks++;
                if (gnt_vld !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_vld_cont got vld=%b want 1", name, gnt_vld);
                end
            end
            if (gnt_vld && gnt_rdy) begin
                started = 1'b1;
                e  = exp_q.pop_front();
                oh = '0;
                oh[e] = 1'b1;
                checks++;
                if (gnt_num !== e || gnt_onehot !== oh) begin
                    errors++;
                    $display("FAIL %s_gnt got num=%0d oh=%b want num=%0d oh=%b", name, gnt_num, gnt_onehot, e, oh);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout got %0d grants pending want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_rotation();
        do_reset();
        for (int i = 0; i < 9; i++) exp_q.push_back(NW'(i % 8));
        req     = '1;
        gnt_rdy = 1'b1;
        run_stream("rotation", 1'b1);
    endtask

    task automatic test_weight();
        logic [NW-1:0] seq [8] = '{3'd0, 3'd0, 3'd0, 3'd7, 3'd0, 3'd0, 3'd0, 3'd7};
        do_reset();
        foreach (seq[i]) exp_q.push_back(seq[i]);
        weight[0*WW +: WW] = WW'(3);
        weight[7*WW +: WW] = WW'(0);
        req     = 8'b1000_0001;
        gnt_rdy = 1'b1;
        run_stream("weight", 1'b1);
    endtask

    task automatic test_lock();
        logic [NW-1:0] e;
        int cnt;
        int stall;
        cnt   = 0;
        stall = 0;
        do_reset();
        for (int i = 0; i < 4; i++) exp_q.push_back(NW'(1));
        for (int i = 0; i < 4; i++) exp_q.push_back(NW'(2));
        lock_en = 1'b1;
        req     = 8'b0000_0110;
        for (int c = 0; c < 60 && exp_q.size() != 0; c++) begin
            @(negedge clks);
            if (cnt == 2 && stall < 5) begin
                gnt_rdy = 1'b0;
                stall++;
                checks++;
                if (gnt_vld !== 1'b1 || gnt_num !== NW'(1)) begin
                    errors++;
                    $display("FAIL lock_frozen got vld=%b num=%0d want 1 1", gnt_vld, gnt_num);
                end
            end else begin
                gnt_rdy = 1'b1;
                eop     = ((cnt % 4) == 3);
                if (gnt_vld) begin
                    e = exp_q.pop_front();
                    cnt++;
                    checks++;
                    if (gnt_num !== e) begin
                        errors++;
                        $display("FAIL lock_gnt got num=%0d want %0d", gnt_num, e);
                    end
                end
            end
        end
        checks++;
        if (exp_q.size() != 0 || stall != 5) begin
            errors++;
            $display("FAIL lock_timeout got pending=%0d stalls=%0d want 0 5", exp_q.size(), stall);
            exp_q.delete();
        end
    endtask

    task automatic test_single();
        do_reset();
        for (int i = 0; i < 5; i++) exp_q.push_back(NW'(4));
        req     = 8'b0001_0000;
        gnt_rdy = 1'b1;
        run_stream("single", 1'b1);
        req = '0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clks);
            checks++;
            if (gnt_vld !== 1'b0 || gnt_onehot !== '0) begin
                errors++;
                $display("FAIL single_to_idle got vld=%b oh=%b want 0 0", gnt_vld, gnt_onehot);
            end
        end
    endtask

    task automatic test_drop();
        logic [NW-1:0] seq [4] = '{3'd5, 3'd0, 3'd3, 3'd5};
        do_reset();
        req     = 8'b0010_0000;
        gnt_rdy = 1'b0;
        @(negedge clks);
        req = '0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (gnt_vld !== 1'b1 || gnt_num !== NW'(5)) begin
                errors++;
                $display("FAIL drop_hold got vld=%b num=%0d want 1 5", gnt_vld, gnt_num);
            end
            if (k < 3) @(negedge clks);
        end
        foreach (seq[i]) exp_q.push_back(seq[i]);
        req     = 8'b0010_1001;
        gnt_rdy = 1'b1;
        // The current negedge already shows a transfer of channel 5.
        checks++;
        if (gnt_num !== exp_q.pop_front()) begin
            errors++;
            $display("FAIL drop_release got num=%0d want 5", gnt_num);
        end
        run_stream("drop", 1'b1);
    endtask

    task automatic test_async_reset();
        do_reset();
        lock_en = 1'b1;
        eop     = 1'b0;
        req     = 8'b0100_0000;
        gnt_rdy = 1'b1;
        repeat (3) @(negedge clks);
        checks++;
        if (gnt_vld !== 1'b1 || gnt_num !== NW'(6)) begin
            errors++;
            $display("FAIL areset_pre got vld=%b num=%0d want 1 6", gnt_vld, gnt_num);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (gnt_vld !== 1'b0 || gnt_num !== '0 || gnt_onehot !== '0) begin
            errors++;
            $display("FAIL areset_immediate got vld=%b num=%0d oh=%b want 0 0 0", gnt_vld, gnt_num, gnt_onehot);
        end
        req     = '1;
        lock_en = 1'b0;
        @(negedge clks);
        checks++;
        if (gnt_vld !== 1'b0) begin
            errors++;
            $display("FAIL areset_held got vld=%b want 0", gnt_vld);
        end
        reset = 1'b0;
        @(negedge clks);
        checks++;
        if (gnt_vld !== 1'b1 || gnt_num !== '0 || gnt_onehot !== 8'b0000_0001) begin
            errors++;
            $display("FAIL areset_first got vld=%b num=%0d oh=%b want 1 0 00000001", gnt_vld, gnt_num, gnt_onehot);
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_weight();
        test_lock();
        test_single();
        test_drop();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arb_n.md
# rr_arb_n

Parametrised round-robin arbiter for REQ_NUM requesters. It holds a registered grant with a valid/ready handshake toward the shared resource. Each grant is held for either a weighted number of transfers (burst credit) or a whole packet (lock mode). Rotation resumes one position past the last released channel. It sits in front of shared DMA/queue resources in place of the fixed 4-way pointer arbiter, wherever channel count, fairness weighting or packet atomicity is required.

## Interface
- REQ_NUM, 8, number of requesting channels (2..32)
- REQ_NUM_W, 3, width of channel index, must equal clog2(REQ_NUM)
- WT_W, 4, width of per-channel weight
- clks  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  REQ_NUM  per-channel request, level
- weight  in  REQ_NUM*WT_W  per-channel burst credit; channel i at [i*WT_W +: WT_W]; value 0 is treated as 1
- lock_en  in  1  1 = packet mode: grant held until a transfer with eop=1
- eop  in  1  end-of-packet qualifier, sampled only on a transfer
- gnt_rdy  in  1  downstream accepts the current transfer
- gnt_vld  out  1  grant valid, registered
- gnt_num  out  REQ_NUM_W  granted channel index, registered
- gnt_onehot  out  REQ_NUM  one-hot of gnt_num, qualified by gnt_vld (all zero when gnt_vld=0)

## Operation
- Internal state: ptr (REQ_NUM_W, last released channel), credit (WT_W), FSM {IDLE, HOLD}.
- Transfer = gnt_vld & gnt_rdy.
- Winner search: first set bit of req starting at (ptr+1) mod REQ_NUM, wrapping ascending. The channel equal to ptr has lowest priority. Wrap arithmetic is modulo REQ_NUM, not 2^REQ_NUM_W.
- IDLE: gnt_vld=0. If req≠0, load gnt_num=winner, gnt_vld=1, credit=max(weight[winner],1), then go to HOLD. Otherwise stay.
- HOLD, no transfer: grant frozen. gnt_num, credit and ptr are unchanged, and changes on req have no effect. A granted channel dropping req does not revoke the grant.
- HOLD, transfer, lock_en=1 and eop=0: stay; credit unchanged.
- HOLD, transfer, lock_en=0 or eop=1 (burst unit complete):
  - credit decrements by 1.
  - If the new credit≠0 and req[gnt_num]=1 and lock_en=0, stay.
  - Otherwise release: ptr <= gnt_num. In the same cycle, re-arbitrate using the updated ptr and the current req.
  - If any request is present, load the new winner (the same channel only if it is the sole requester), reload credit, and stay in HOLD with gnt_vld=1 (no bubble).
  - Otherwise go to IDLE with gnt_vld=0.
- In lock mode, each packet consumes one credit and the packet boundary takes precedence. After release the channel re-enters rotation normally.
- lock_en and weight are sampled at each transfer/grant. Changing them mid-grant affects only subsequent decisions.

## Timing
- Reset values: gnt_vld=0, gnt_num=0, gnt_onehot=0, credit=0, ptr=REQ_NUM-1 (channel 0 has first priority), FSM=IDLE.
- Latency: req asserted at cycle N while IDLE produces gnt_vld=1 at cycle N+1.
- Back-to-back handoff: a releasing transfer at cycle N produces the new grant at cycle N+1, with zero idle cycles between channels.
- gnt_vld, once high, stays high until a releasing transfer, irrespective of req.
- Reset asserted mid-grant clears all state asynchronously. The first grant after deassertion again starts from channel 0.
- Throughput: one transfer per cycle while gnt_rdy=1.

## Test plan
- Reset, then req=8'hFF, weights all 1, lock_en=0, gnt_rdy=1 -> gnt_num sequence 0,1,2,...,7,0 on consecutive cycles; gnt_vld continuously 1 from the first grant.
- req=8'b1000_0001, weight[0]=3, weight[7]=0, gnt_rdy=1 -> grants 0,0,0,7,0,0,0,7 (weight 0 behaves as 1).
- lock_en=1, req=8'b0000_0110, eop pulsed on every 4th transfer -> channel 1 holds for 4 transfers, then channel 2 for 4; gnt_rdy held low for 5 cycles mid-packet keeps gnt_num frozen.
- Single requester req=8'b0001_0000, weight 1 -> channel 4 re-granted each cycle without gnt_vld dropping. Then req→0 -> after the releasing transfer gnt_vld=0 and the FSM returns to IDLE.
- Granted channel 5 drops req with gnt_rdy=0 -> grant persists; on the next transfer it is released and ptr=5, so with req=8'b0010_1001 the next grant is channel 0.
- Assert reset while channel 6 holds a locked packet -> outputs zero immediately. After release with req=8'hFF, the first grant is channel 0.
